riscv_hazard_detection_unit: RTL and testbench
==============================================

RISCV_HAZARD_DETECTION_UNIT -- requirements
Module: riscv_hazard_detection_unit

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for the event counters.
REQ-003 reset  input  1  synchronous, active-high; clears the counters.
REQ-004 zero  input  1  ALU result equals zero (EX stage).
REQ-005 lessThan  input  1  ALU compare result; signed for BLT/BGE, unsigned for BLTU/BGEU, generated upstream.
REQ-006 opcode  input  7  opcode of the instruction in EX.
REQ-007 func3  input  3  func3 of the instruction in EX.
REQ-008 memRead  input  1  instruction in EX is a load.
REQ-009 exRd  input  5  destination register of the instruction in EX.
REQ-010 idRs1, idRs2  input  5 each  source registers of the instruction in ID.
REQ-011 pcSrc  output  1  1 = select branch/jump target as next PC.
REQ-012 flush  output  1  1 = squash the IF/ID and ID/EX contents.
REQ-013 stall  output  1  1 = hold PC and IF/ID, insert a bubble into EX.
REQ-014 flushCount  output  16  number of cycles with flush=1 since reset.
REQ-015 stallCount  output  16  number of cycles with stall=1 since reset.

Function
REQ-016 pcSrc, flush and stall SHALL be purely combinational from the current inputs, with zero-cycle latency and no dependence on clk or reset.
REQ-017 For opcode 1101111 (JAL) and 1100111 (JALR), pcSrc SHALL be 1 regardless of func3, zero and lessThan.
REQ-018 For opcode 1100011 (branch), pcSrc SHALL be 1 as follows:
- func3 000 (BEQ): when zero=1.
- func3 001 (BNE): when zero=0.
- func3 100 (BLT) or 110 (BLTU): when lessThan=1.
- func3 101 (BGE) or 111 (BGEU): when lessThan=0.
REQ-019 For branch opcodes with func3 010 or 011, pcSrc SHALL be 0.
REQ-020 For every other opcode (including 0000000), pcSrc SHALL be 0.
REQ-021 flush SHALL equal pcSrc at all times.
REQ-022 The raw load-use condition SHALL be memRead=1 AND exRd!=0 AND (exRd==idRs1 OR exRd==idRs2).
REQ-023 stall SHALL be the raw load-use condition AND NOT pcSrc, because a taken control transfer squashes the dependent ID instruction.
REQ-024 Any X/Z on the inputs SHALL NOT be masked; there are no defined outputs for unknown inputs.
REQ-025 On each rising clk edge with reset=0, flushCount SHALL increment by 1 if flush=1, and stallCount SHALL increment by 1 if stall=1.
REQ-026 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-027 flush and stall are mutually exclusive by construction, so the two counters SHALL never increment in the same cycle.

Reset
REQ-028 On a rising clk edge with reset=1, flushCount and stallCount SHALL become 0; reset SHALL take priority over any increment in that cycle.
REQ-029 Reset SHALL NOT affect pcSrc, flush or stall, which follow their inputs even while reset=1.
REQ-030 Reset asserted mid-operation SHALL clear the counters at the next edge with no other side effect.

Verification
REQ-031 opcode=0, func3=0, all other inputs 0 -> pcSrc=0, flush=0, stall=0.
REQ-032 opcode=1100111, func3=0 -> pcSrc=1, flush=1 immediately, with no clock edge needed; opcode=1101111 gives the same result.
REQ-033 opcode=1100011 with each of these cases -> pcSrc=1:
- func3=000, zero=1.
- func3=001, zero=0.
- func3=100, lessThan=1.
- func3=111, lessThan=0.
The inverse condition in each case -> pcSrc=0; func3=010 -> pcSrc=0.
REQ-034 memRead=1, exRd=5, idRs2=5, opcode=0110011 -> stall=1.
- Same with exRd=0 -> stall=0.
- Same with opcode=1101111 -> stall=0, flush=1.
REQ-035 After reset, hold opcode=1101111 for 3 edges, then memRead=1, exRd=idRs1=7 with opcode=0 for 2 edges -> flushCount=3, stallCount=2; one edge with reset=1 -> both counters 0.
REQ-036 Preload the counter by 65540 flush cycles -> flushCount=16'hFFFF and it holds there.

Source files
------------

// File: rtl/riscv_hazard_detection_unit.sv
// Branch/jump resolution, load-use stall detection and flush/stall event counters.
// Control outputs are purely combinational; only the counters are clocked.
module riscv_hazard_detection_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        zero,
    input  logic        lessThan,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func3,
    input  logic        memRead,
    input  logic [4:0]  exRd,
    input  logic [4:0]  idRs1,
    input  logic [4:0]  idRs2,
    output logic        pcSrc,
    output logic        flush,
    output logic        stall,
    output logic [15:0] flushCount,
    output logic [15:0] stallCount
);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    logic is_jump;
    logic is_branch;
    logic br_taken;
    logic load_use;

    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);

    always_comb begin
        br_taken = 1'b0;
        case (func3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = !zero;
            3'b100:  br_taken = lessThan;
            3'b110:  br_taken = lessThan;
            3'b101:  br_taken = !lessThan;
            3'b111:  br_taken = !lessThan;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pcSrc = 1'b0;
        unique case (1'b1)
            is_jump:   pcSrc = 1'b1;
            is_branch: pcSrc = br_taken;
            default:   pcSrc = 1'b0;
        endcase
    end

    assign flush = pcSrc;

    // A taken transfer squashes the dependent ID instruction, so no stall is needed.
    assign load_use = memRead && (exRd != 5'd0) &&
                      ((exRd == idRs1) || (exRd == idRs2));
    assign stall    = load_use && !pcSrc;

    always_ff @(posedge clk) begin
        if (reset) begin
            flushCount <= 16'd0;
            stallCount <= 16'd0;
        end else begin
            if (flush && (flushCount != CNT_MAX))
                flushCount <= flushCount + 16'd1;
            if (stall && (stallCount != CNT_MAX))
                stallCount <= stallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_riscv_hazard_detection_unit.sv
// Scoreboard bench for riscv_hazard_detection_unit: driver queues expectations,
// negedge monitor pops and compares outputs and counters.
module tb_riscv_hazard_detection_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        zero;
    logic        lessThan;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        memRead;
    logic [4:0]  exRd;
    logic [4:0]  idRs1;
    logic [4:0]  idRs2;
    logic        pcSrc;
    logic        flush;
    logic        stall;
    logic [15:0] flushCount;
    logic [15:0] stallCount;

    localparam logic [6:0] JAL  = 7'b1101111;
    localparam logic [6:0] JALR = 7'b1100111;
    localparam logic [6:0] BR   = 7'b1100011;
    localparam logic [6:0] RTY  = 7'b0110011;
    localparam logic [6:0] LD   = 7'b0000011;

    typedef struct {
        string       name;
        logic        p;
        logic        s;
        logic [15:0] fc;
        logic [15:0] sc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    riscv_hazard_detection_unit dut (
        .clk        (clk),
        .reset      (reset),
        .zero       (zero),
        .lessThan   (lessThan),
        .opcode     (opcode),
        .func3      (func3),
        .memRead    (memRead),
        .exRd       (exRd),
        .idRs1      (idRs1),
        .idRs2      (idRs2),
        .pcSrc      (pcSrc),
        .flush      (flush),
        .stall      (stall),
        .flushCount (flushCount),
        .stallCount (stallCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld,
                       input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, after the driver's update.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "pcSrc", {15'd0, pcSrc}, {15'd0, e.p});
            chk(e.name, "flush", {15'd0, flush}, {15'd0, e.p});
            chk(e.name, "stall", {15'd0, stall}, {15'd0, e.s});
            chk(e.name, "flushCount", flushCount, e.fc);
            chk(e.name, "stallCount", stallCount, e.sc);
        end
    end

    task automatic drive(input logic rs, input logic [6:0] op,
                         input logic [2:0] f3, input logic z,
                         input logic lt, input logic mr,
                         input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2);
        @(posedge clk);
        #1;
        reset    = rs;
        opcode   = op;
        func3    = f3;
        zero     = z;
        lessThan = lt;
        memRead  = mr;
        exRd     = rd;
        idRs1    = r1;
        idRs2    = r2;
    endtask

    // Counter expectations are the values after the edges of all prior vectors.
    task automatic vec(input string nm, input logic rs, input logic [6:0] op,
                       input logic [2:0] f3, input logic z, input logic lt,
                       input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic ep, input logic es,
                       input logic [15:0] efc, input logic [15:0] esc);
        exp_t e;
        drive(rs, op, f3, z, lt, mr, rd, r1, r2);
        e.name = nm;
        e.p    = ep;
        e.s    = es;
        e.fc   = efc;
        e.sc   = esc;
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b1; opcode = '0; func3 = '0; zero = 1'b0;
        lessThan = 1'b0; memRead = 1'b0; exRd = '0; idRs1 = '0; idRs2 = '0;
        repeat (2) @(posedge clk);

        vec("rst_hold",   1, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("all_zero",   0, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vec("jalr",       0, JALR, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vec("jal_any",    0, JAL,  3'b101, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0);
        vec("beq_t",      0, BR,   3'b000, 1, 0, 0, 0, 0, 0, 1, 0, 2, 0);
        vec("beq_nt",     0, BR,   3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0);
        vec("bne_t",      0, BR,   3'b001, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0);
        vec("bne_nt",     0, BR,   3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 4, 0);
        vec("blt_t",      0, BR,   3'b100, 0, 1, 0, 0, 0, 0, 1, 0, 4, 0);
        vec("blt_nt",     0, BR,   3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        vec("bgeu_t",     0, BR,   3'b111, 0, 0, 0, 0, 0, 0, 1, 0, 5, 0);
        vec("bgeu_nt",    0, BR,   3'b111, 1, 1, 0, 0, 0, 0, 0, 0, 6, 0);
        vec("bltu_t",     0, BR,   3'b110, 0, 1, 0, 0, 0, 0, 1, 0, 6, 0);
        vec("bge_t",      0, BR,   3'b101, 1, 0, 0, 0, 0, 0, 1, 0, 7, 0);
        vec("br_f010",    0, BR,   3'b010, 1, 1, 0, 0, 0, 0, 0, 0, 8, 0);
        vec("br_f011",    0, BR,   3'b011, 0, 0, 0, 0, 0, 0, 0, 0, 8, 0);
        vec("rtype",      0, RTY,  3'b000, 1, 1, 0, 0, 0, 0, 0, 0, 8, 0);
        vec("lu_rs2",     0, RTY,  3'b000, 0, 0, 1, 5, 0, 5, 0, 1, 8, 0);
        vec("lu_x0",      0, RTY,  3'b000, 0, 0, 1, 0, 0, 5, 0, 0, 8, 1);
        vec("lu_jal",     0, JAL,  3'b000, 0, 0, 1, 5, 0, 5, 1, 0, 8, 1);
        vec("lu_nomr",    0, RTY,  3'b000, 0, 0, 0, 5, 0, 5, 0, 0, 9, 1);
        vec("lu_rs1",     0, LD,   3'b010, 0, 0, 1, 9, 9, 3, 0, 1, 9, 1);
        vec("lu_nomatch", 0, LD,   3'b010, 0, 0, 1, 9, 4, 2, 0, 0, 9, 2);
        vec("rst_jal",    1, JAL,  3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 9, 2);
        vec("post_rst",   0, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vec("cnt_j1",     0, JAL,  3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        vec("cnt_j2",     0, JAL,  3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        vec("cnt_j3",     0, JAL,  3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0);
        vec("cnt_s1",     0, 7'd0, 3'b000, 0, 0, 1, 7, 7, 0, 0, 1, 3, 0);
        vec("cnt_s2",     0, 7'd0, 3'b000, 0, 0, 1, 7, 7, 0, 0, 1, 3, 1);
        vec("cnt_3_2",    0, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        vec("cnt_rst",    1, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3, 2);
        vec("cnt_clr",    0, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Preload past the saturation point without queuing checks.
        repeat (65540) drive(0, JAL, 3'b000, 0, 0, 0, 0, 0, 0);
        vec("sat_jal",    0, JAL,  3'b000, 0, 0, 0, 0, 0, 0, 1, 0, 16'hFFFF, 0);
        vec("sat_hold",   0, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0);
        vec("sat_rst",    1, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF, 0);
        vec("sat_clr",    0, 7'd0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
